// File: rtl/uart_tx_if.sv
// Write port of the UART transmitter: valid/ready byte handshake from the CPU side.
interface uart_tx_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx.sv
// Byte UART transmitter: FIFO-buffered write port, 8N1 LSB-first serialiser on TXD.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic      CLK,
  input  logic      RESET,
  uart_tx_if.slave  wr,
  output logic      TXD,
  output logic      busy
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_d, busy_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          push, pop, bit_end;
  logic [7:0]    head;

  assign wr.wr_ready = ready_q;
  assign head        = mem[rptr_q];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = 1'b1;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (baud_q == BAUD_LAST);
    if (state_q != IDLE)
      baud_d = bit_end ? '0 : baud_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          baud_d  = '0;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = sh_q[0];
        end
      end
      DATA: begin
        txd_d = sh_q[0];
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            txd_d = sh_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_d = par_q;
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      sh_d  = head;
      bit_d = '0;
`ifdef UART_TX_PARITY_EN
      par_d = ^head;
`endif
    end
  end

  always_comb begin
    push   = wr.wr_valid && ready_q;
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != CNT_FULL);
    busy_d  = (state_d != IDLE) || (cnt_d != '0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      TXD     <= 1'b1;
      busy    <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      TXD     <= txd_d;
      busy    <= busy_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wptr_q] <= wr.wr_data;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one DUT at DIV=8, FIFO_DEPTH=4, and one at default parameters (DIV=104).
module tb_uart_tx;

  localparam int unsigned DIV  = 8;
  localparam int unsigned DIVD = 104;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic txd, busy, txd_d, busy_d;
  int   checks = 0;
  int   errors = 0;

  uart_tx_if wif();
  uart_tx_if dif();

  uart_tx #(.CLK_FREQ_HZ(8), .BAUD_RATE(1), .FIFO_DEPTH(4)) u_dut (
    .CLK(CLK), .RESET(RESET), .wr(wif), .TXD(txd), .busy(busy)
  );

  uart_tx u_dut_def (
    .CLK(CLK), .RESET(RESET), .wr(dif), .TXD(txd_d), .busy(busy_d)
  );

  always #5 CLK = ~CLK;

  // Line level of frame bit k: 0 start, 1..8 data LSB first, optional parity, then stop.
  function automatic logic exp_bit(input logic [7:0] b, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    @(negedge CLK);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wif.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wif.wr_ready); end
    checks++; if (txd_d !== 1'b1) begin errors++; $display("FAIL reset_txd_def: got %b want 1", txd_d); end
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: txd %b busy %b want 1 0", txd, busy); end
  endtask

  task automatic test_single_frame();
    @(posedge CLK); #1;
    wif.wr_valid = 1'b1; wif.wr_data = 8'h55;
    @(posedge CLK); #1;
    wif.wr_valid = 1'b0;
    @(negedge CLK);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL single_latency: txd %b want 1 before start edge", txd); end
    for (int unsigned k = 0; k < NB; k++)
      for (int unsigned c = 0; c < DIV; c++) begin
        @(negedge CLK);
        checks++; if (txd !== exp_bit(8'h55, k)) begin errors++; $display("FAIL single_bit%0d_cyc%0d: txd %b want %b", k, c, txd, exp_bit(8'h55, k)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy bit%0d cyc%0d: got %b want 1", k, c, busy); end
      end
    @(negedge CLK);
    checks++; if (busy !== 1'b0 || txd !== 1'b1) begin errors++; $display("FAIL single_end: busy %b txd %b want 0 1", busy, txd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    @(posedge CLK); #1;
    wif.wr_valid = 1'b1; wif.wr_data = 8'hA5;
    @(posedge CLK); #1;
    wif.wr_data = 8'h3C;
    @(posedge CLK); #1;
    wif.wr_valid = 1'b0;
    for (int unsigned f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'hA5 : 8'h3C;
      for (int unsigned k = 0; k < NB; k++)
        for (int unsigned c = 0; c < DIV; c++) begin
          @(negedge CLK);
          checks++; if (txd !== exp_bit(b, k)) begin errors++; $display("FAIL b2b_f%0d_bit%0d_cyc%0d: txd %b want %b", f, k, c, txd, exp_bit(b, k)); end
        end
    end
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_fifo_full();
    int unsigned n;
    logic [7:0]  b;
    @(posedge CLK); #1;
    wif.wr_valid = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      wif.wr_data = 8'(i + 1);
      @(negedge CLK);
      checks++; if (wif.wr_ready !== (i < 5)) begin errors++; $display("FAIL full_ready_cyc%0d: got %b want %b", i, wif.wr_ready, (i < 5)); end
      checks++; if (txd !== (i < 2)) begin errors++; $display("FAIL full_start_cyc%0d: txd %b want %b", i, txd, (i < 2)); end
      @(posedge CLK); #1;
    end
    n = 0;
    for (int unsigned w = 1; w <= 200; w++) begin
      @(negedge CLK);
      n = w;
      if (wif.wr_ready === 1'b1) break;
    end
    checks++; if (n != NB * DIV - 3) begin errors++; $display("FAIL full_ready_return: after %0d cycles want %0d", n, NB * DIV - 3); end
    for (int unsigned f = 0; f < 5; f++) begin
      b = 8'(f + 2);
      for (int unsigned k = 0; k < NB; k++)
        for (int unsigned c = 0; c < DIV; c++) begin
          if (!(f == 0 && k == 0 && c == 0)) @(negedge CLK);
          if (f == 0 && k == 0 && c == 1) wif.wr_valid = 1'b0;
          checks++; if (txd !== exp_bit(b, k)) begin errors++; $display("FAIL full_f%0d_bit%0d_cyc%0d: txd %b want %b", f, k, c, txd, exp_bit(b, k)); end
        end
    end
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_midframe();
    @(posedge CLK); #1;
    wif.wr_valid = 1'b1; wif.wr_data = 8'hFF;
    @(posedge CLK); #1; wif.wr_data = 8'h11;
    @(posedge CLK); #1; wif.wr_data = 8'h22;
    @(posedge CLK); #1; wif.wr_data = 8'h33;
    @(posedge CLK); #1; wif.wr_data = 8'h44;
    @(posedge CLK); #1; wif.wr_valid = 1'b0;
    @(negedge CLK);
    checks++; if (wif.wr_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_ready: got %b want 0", wif.wr_ready); end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rst_pre_start: txd %b want 0", txd); end
    repeat (27) @(posedge CLK);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
    #1 RESET = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_async_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    checks++; if (wif.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b want 1", wif.wr_ready); end
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge CLK);
      checks++; if (txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_flushed_cyc%0d: txd %b busy %b want 1 0", i, txd, busy); end
    end
    @(posedge CLK); #1;
    wif.wr_valid = 1'b1; wif.wr_data = 8'h81;
    @(posedge CLK); #1;
    wif.wr_valid = 1'b0;
    @(negedge CLK);
    for (int unsigned k = 0; k < NB; k++)
      for (int unsigned c = 0; c < DIV; c++) begin
        @(negedge CLK);
        checks++; if (txd !== exp_bit(8'h81, k)) begin errors++; $display("FAIL rst_frame_bit%0d_cyc%0d: txd %b want %b", k, c, txd, exp_bit(8'h81, k)); end
      end
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_frame_busy_end: got %b want 0", busy); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] b;
    logic       want;
    for (int unsigned t = 0; t < 2; t++) begin
      b    = (t == 0) ? 8'h07 : 8'h03;
      want = (t == 0) ? 1'b1 : 1'b0;
      @(posedge CLK); #1;
      wif.wr_valid = 1'b1; wif.wr_data = b;
      @(posedge CLK); #1;
      wif.wr_valid = 1'b0;
      @(negedge CLK);
      for (int unsigned k = 0; k < 11; k++)
        for (int unsigned c = 0; c < DIV; c++) begin
          @(negedge CLK);
          if (k == 9) begin
            checks++; if (txd !== want) begin errors++; $display("FAIL parity_%h_cyc%0d: txd %b want %b", b, c, txd, want); end
          end else begin
            checks++; if (txd !== exp_bit(b, k)) begin errors++; $display("FAIL parity_%h_bit%0d: txd %b want %b", b, k, txd, exp_bit(b, k)); end
          end
        end
      @(negedge CLK);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_%h_busy_end: got %b want 0", b, busy); end
    end
  endtask
`endif

  task automatic test_default_div();
    @(posedge CLK); #1;
    dif.wr_valid = 1'b1; dif.wr_data = 8'h00;
    @(posedge CLK); #1;
    dif.wr_valid = 1'b0;
    @(negedge CLK);
    checks++; if (txd_d !== 1'b1) begin errors++; $display("FAIL def_latency: txd %b want 1", txd_d); end
    for (int unsigned k = 0; k < NB; k++)
      for (int unsigned c = 0; c < DIVD; c++) begin
        @(negedge CLK);
        checks++; if (txd_d !== exp_bit(8'h00, k)) begin errors++; $display("FAIL def_bit%0d_cyc%0d: txd %b want %b", k, c, txd_d, exp_bit(8'h00, k)); end
      end
    @(negedge CLK);
    checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL def_busy_end: got %b want 0", busy_d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wif.wr_valid = 1'b0; wif.wr_data = 8'h00;
    dif.wr_valid = 1'b0; dif.wr_data = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_full();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_default_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-oriented UART transmitter that drives the SOC's currently idle TXD pin.
- Accepts bytes from the CPU side through a valid/ready write port and buffers them in a small FIFO.
- Serialises each byte as 8N1, LSB first, at a fixed baud rate derived from the system clock.
- Complements the RXD input; it becomes the console/debug output path for the RISC-V core.

Parameters:
- CLK_FREQ_HZ, 12000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s. DIV = CLK_FREQ_HZ / BAUD_RATE, truncating integer division; DIV >= 2 is required.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, >= 2.

Ports:
- CLK  input  1  system clock, all logic on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- wr_valid  input  1  write request; wr_data is valid while high.
- wr_data  input  8  byte to transmit.
- wr_ready  output  1  FIFO can accept a byte (not full). Registered; never depends combinationally on wr_valid.
- TXD  output  1  serial line, idle high. Registered output.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.

Behaviour:
- Interface: one clock, CLK; reset RESET is asynchronous and active-high.
- Reset values: TXD=1, wr_ready=1, busy=0, FIFO empty, FSM in IDLE, baud counter 0, bit index 0.
- Reset asserted mid-frame: TXD returns to 1 immediately (asynchronously), the frame is aborted and FIFO contents are discarded.
- Write handshake: a byte is pushed on a rising edge where wr_valid && wr_ready.
  - A write while full (wr_ready=0) is ignored; the producer holds wr_valid and wr_data.
  - wr_ready = !full, updated on the same edge as the pointer and count changes.
- FIFO:
  - Read and write pointers of width log2(FIFO_DEPTH), wrapping modulo FIFO_DEPTH.
  - Occupancy count 0..FIFO_DEPTH.
  - Simultaneous push and pop in one cycle leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled).
  - IDLE: TXD=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter and go to START. TXD drives 0 on that same edge.
  - Latency: a byte accepted into an empty FIFO with the FSM in IDLE drives TXD low 1 cycle after the accepting edge.
  - START: TXD=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: TXD = shift_reg[0], each bit held DIV cycles. Shift right at the end of each bit period. After bit index 7 completes, go to STOP.
  - STOP: TXD=1 for DIV cycles. At the end of the period:
    - FIFO non-empty: pop and go directly to START, so there is no idle gap between frames.
    - FIFO empty: go to IDLE.
- Baud counter: counts 0..DIV-1 and wraps to 0 at the end of each bit period. Bit period is exactly DIV cycles and frame length exactly 10*DIV cycles.
- busy: registered; busy = (state != IDLE) || (count != 0). It falls on the edge where STOP completes with an empty FIFO.
- wr_data changing while not accepted has no effect on the line.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - TXD = XOR of the 8 data bits (even parity), held for DIV cycles.
  - Frame length is 11*DIV cycles.
- Undefined:
  - No PARITY state and no parity logic; 8N1 frames of 10*DIV cycles.

Test Plan:
- CLK_FREQ_HZ=8, BAUD_RATE=1 (DIV=8); push 0x55 once -> TXD low 1 cycle after the accepting edge; TXD sequence 0,1,0,1,0,1,0,1,0,1 with each bit 8 cycles; busy falls exactly 80 cycles after TXD first goes low.
- Same DIV; push 0xA5 then 0x3C on consecutive cycles -> second start bit begins on the cycle right after the first stop bit ends; 160 cycles total; data bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- FIFO_DEPTH=4; wr_valid held high for 6 cycles with bytes 0x01..0x06 -> 0x01 is popped on the edge after its push; 0x02..0x05 fill the FIFO; wr_ready=0 on the 6th cycle; 0x06 is not accepted until after the first frame's STOP.
- Assert RESET at cycle 30 of a 0xFF frame -> TXD=1, busy=0 and wr_ready=1 immediately; after release, push 0x81 -> a clean frame 0,1,0,0,0,0,0,0,1,1.
- UART_TX_PARITY_EN defined, DIV=8; push 0x07 -> parity bit 1 after bit 7; frame lasts 88 cycles. Push 0x03 -> parity bit 0.
- Defaults (DIV=104); push 0x00 -> start bit plus 8 data bits give 936 consecutive low cycles, then stop bit high for 104 cycles.
